// File: rtl/tmp125_poller.sv
// Round-robin SPI poller for TMP125-compatible thermometers on a shared SCK/SO bus.
// Extracts 10-bit temperatures per channel and flags malformed frames.
module tmp125_poller #(
  parameter int NUM_CH        = 4,
  parameter int CLK_DIV       = 50,
  parameter int POLL_INTERVAL = 1000000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_poll_en,
  output logic                   o_spi_clk,
  output logic [NUM_CH-1:0]      o_spi_cs_n,
  input  logic                   i_spi_so,
  output logic [10*NUM_CH-1:0]   o_temp,
  output logic [NUM_CH-1:0]      o_temp_valid,
  output logic [NUM_CH-1:0]      o_fault,
  output logic                   o_upd,
  output logic [2:0]             o_upd_ch,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_GAP, S_DONE
  } state_t;

  localparam int DIV_W  = $clog2(2*CLK_DIV);
  localparam int ICNT_W = $clog2(POLL_INTERVAL+1);
  localparam logic [DIV_W-1:0]  HALF_LAST = DIV_W'(CLK_DIV-1);
  localparam logic [DIV_W-1:0]  FULL_LAST = DIV_W'(2*CLK_DIV-1);
  localparam logic [ICNT_W-1:0] ICNT_MAX  = ICNT_W'(POLL_INTERVAL);
  localparam logic [2:0]        LAST_CH   = 3'(NUM_CH-1);

  state_t              state, state_nx;
  logic [DIV_W-1:0]    div_cnt, div_cnt_nx;
  logic [3:0]          bit_cnt, bit_cnt_nx;
  logic [2:0]          ch, ch_nx;
  logic [10:0]         shreg;
  logic [ICNT_W-1:0]   icnt;
  logic                start_cond, sample, frame_end;
  logic                sck_nx;
  logic [NUM_CH-1:0]   cs_n_nx;

  always_comb begin
    state_nx   = state;
    div_cnt_nx = div_cnt + DIV_W'(1);
    bit_cnt_nx = bit_cnt;
    ch_nx      = ch;
    start_cond = (state == S_IDLE) && (i_start || (i_poll_en && (icnt == ICNT_MAX)));
    sample     = (state == S_SHIFT) && (div_cnt == HALF_LAST);
    frame_end  = (state == S_CS_HOLD) && (div_cnt == HALF_LAST);
    case (state)
      S_IDLE: begin
        div_cnt_nx = '0;
        if (start_cond) begin
          ch_nx    = '0;
          state_nx = S_CS_SETUP;
        end
      end
      S_CS_SETUP: begin
        if (div_cnt == HALF_LAST) begin
          div_cnt_nx = '0;
          bit_cnt_nx = '0;
          state_nx   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_cnt == FULL_LAST) begin
          div_cnt_nx = '0;
          bit_cnt_nx = bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) state_nx = S_CS_HOLD;
        end
      end
      S_CS_HOLD: begin
        if (frame_end) begin
          div_cnt_nx = '0;
          state_nx   = S_GAP;
        end
      end
      S_GAP: begin
        if (div_cnt == HALF_LAST) begin
          div_cnt_nx = '0;
          if (ch == LAST_CH) begin
            state_nx = S_DONE;
          end else begin
            ch_nx    = ch + 3'd1;
            state_nx = S_CS_SETUP;
          end
        end
      end
      S_DONE: begin
        div_cnt_nx = '0;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // Pin outputs are registered from next-state values so they stay glitch-free
    // while still changing in the same cycle as the state they belong to.
    sck_nx  = !((state_nx == S_SHIFT) && (div_cnt_nx <= HALF_LAST));
    cs_n_nx = '1;
    if (state_nx inside {S_CS_SETUP, S_SHIFT, S_CS_HOLD}) cs_n_nx[ch_nx] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      ch           <= '0;
      shreg        <= '0;
      icnt         <= '0;
      o_spi_clk    <= 1'b1;
      o_spi_cs_n   <= '1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_upd        <= 1'b0;
      o_upd_ch     <= '0;
      o_temp       <= '0;
      o_temp_valid <= '0;
      o_fault      <= '0;
    end else begin
      state      <= state_nx;
      div_cnt    <= div_cnt_nx;
      bit_cnt    <= bit_cnt_nx;
      ch         <= ch_nx;
      o_spi_clk  <= sck_nx;
      o_spi_cs_n <= cs_n_nx;
      o_busy     <= (state_nx != S_IDLE);
      o_done     <= (state_nx == S_DONE);
      o_upd      <= frame_end;

      // Only the status bit and the 10 temperature bits are kept; the tail is don't-care.
      if (sample && (bit_cnt < 4'd11)) shreg <= {shreg[9:0], i_spi_so};

      if (start_cond) begin
        icnt <= '0;
      end else if (((state == S_IDLE) || (state == S_DONE)) && (icnt != ICNT_MAX)) begin
        icnt <= icnt + ICNT_W'(1);
      end

      if (frame_end) begin
        o_upd_ch <= ch;
        if (!shreg[10]) begin
          o_temp[10*int'(ch) +: 10] <= shreg[9:0];
          o_temp_valid[ch]          <= 1'b1;
          o_fault[ch]               <= 1'b0;
        end else begin
          o_fault[ch] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tmp125_poller.sv
// Bench for tmp125_poller: TMP125 sensor models on the bus and a timeline model
// that derives every pin value from the cycle offset within a round.
module tb_tmp125_poller;
  localparam int N      = 4;
  localparam int D      = 4;
  localparam int PI     = 1000;
  localparam int CH_LEN = 35*D;
  localparam int RL     = 1 + 35*D*N;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           poll_en = 1'b0;
  logic           sck;
  logic [N-1:0]   cs_n;
  logic           so = 1'b1;
  logic [10*N-1:0] temp;
  logic [N-1:0]   temp_valid, fault;
  logic           upd, busy, done;
  logic [2:0]     upd_ch;
  logic           cs_idle;

  logic [15:0]    sensor_word [N];
  int             total = 0;
  int             bad = 0;

  always #5 clk = ~clk;

  tmp125_poller #(.NUM_CH(N), .CLK_DIV(D), .POLL_INTERVAL(PI)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_poll_en(poll_en),
    .o_spi_clk(sck), .o_spi_cs_n(cs_n), .i_spi_so(so),
    .o_temp(temp), .o_temp_valid(temp_valid), .o_fault(fault),
    .o_upd(upd), .o_upd_ch(upd_ch), .o_busy(busy), .o_done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sensor: launches the next MSB-first bit on each SCK fall of its selected frame.
  assign cs_idle = &cs_n;
  int bitn = 0;
  always @(negedge sck or posedge cs_idle) begin
    if (cs_idle) begin
      bitn = 0;
      so   = 1'b1;
    end else begin
      for (int k = 0; k < N; k++)
        if (!cs_n[k] && bitn < 16) so = sensor_word[k][15-bitn];
      bitn++;
    end
  end

  // Reference model and per-cycle compare.
  int            n = 0, t_start = 0, anchor = 0;
  bit            active = 1'b0;
  logic [9:0]    m_temp [N];
  logic [N-1:0]  m_valid = '0, m_fault = '0;
  initial begin
    int t, base, upd_k;
    logic e_busy, e_done, e_sck, e_upd;
    logic [N-1:0] e_cs;
    logic [10*N-1:0] e_temp;
    logic [15:0] w;
    for (int k = 0; k < N; k++) m_temp[k] = '0;
    forever begin
      @(negedge clk);
      n++;
      if (rst) begin
        active = 1'b0;
        anchor = n + 1;
        m_valid = '0;
        m_fault = '0;
        for (int k = 0; k < N; k++) m_temp[k] = '0;
        chk("rst_sck", sck, 1);
        chk("rst_cs_n", cs_n, {N{1'b1}});
        chk("rst_temp", temp, 0);
        chk("rst_valid", temp_valid, 0);
        chk("rst_fault", fault, 0);
        chk("rst_upd", upd, 0);
        chk("rst_upd_ch", upd_ch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
      end else begin
        t = n - t_start;
        e_busy = active && (t >= 1);
        e_done = active && (t == RL);
        e_cs = '1; e_sck = 1'b1; e_upd = 1'b0; upd_k = 0;
        if (active) begin
          for (int k = 0; k < N; k++) begin
            base = 1 + CH_LEN*k;
            if (t >= base && t < base + 34*D) e_cs[k] = 1'b0;
            if (t >= base + D && t < base + 33*D && ((t - base - D) % (2*D)) < D) e_sck = 1'b0;
            if (t == base + 34*D) begin e_upd = 1'b1; upd_k = k; end
          end
        end
        if (e_upd) begin
          w = sensor_word[upd_k];
          if (!w[15]) begin
            m_temp[upd_k]  = w[14:5];
            m_valid[upd_k] = 1'b1;
            m_fault[upd_k] = 1'b0;
          end else begin
            m_fault[upd_k] = 1'b1;
          end
        end
        for (int k = 0; k < N; k++) e_temp[10*k +: 10] = m_temp[k];
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("cs_n", cs_n, e_cs);
        chk("sck", sck, e_sck);
        chk("upd", upd, e_upd);
        if (e_upd) chk("upd_ch", upd_ch, upd_k);
        chk("temp", temp, e_temp);
        chk("temp_valid", temp_valid, m_valid);
        chk("fault", fault, m_fault);
        if (active && t == RL) begin
          active = 1'b0;
          anchor = n;
        end else if (!active && (start || (poll_en && (n - anchor >= PI)))) begin
          active  = 1'b1;
          t_start = n;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int limit, output int waited);
    waited = 0;
    while (!done && waited < limit) begin
      tick();
      waited++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s: o_done not seen, got 0 expected 1 within %0d cycles", name, limit);
    end
  endtask

  task automatic run_round(input string name);
    int w;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(name, RL + 10, w);
    chk({name, "_len"}, w + 1, RL);
    tick();
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    w[15] = ($urandom_range(0, 3) == 0);
    return w;
  endfunction

  initial begin
    int cs0_low, sck_falls, w, busy_cnt;
    logic prev_sck;
    sensor_word[0] = 16'h0C80;
    sensor_word[1] = 16'h7B00;
    sensor_word[2] = 16'h0000;
    sensor_word[3] = 16'h3FE0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("init_cs_n", cs_n, 4'hF);
    chk("init_sck", sck, 1);

    // Round-robin read with a mid-round start and a start on the o_done cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    cs0_low = 0; sck_falls = 0; prev_sck = 1'b1;
    for (int i = 1; i < RL; i++) begin
      if (!cs_n[0]) cs0_low++;
      if (!cs_n[0] && prev_sck && !sck) sck_falls++;
      prev_sck = sck;
      start = (i == 300);
      tick();
    end
    chk("rr_done_cycle", done, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_on_done_ignored", busy, 0);
    chk("cs0_low_cycles", cs0_low, 136);
    chk("sck_pulses", sck_falls, 16);
    chk("temp0", temp[9:0], 10'h064);
    chk("temp1", temp[19:10], 10'h3D8);
    chk("temp2", temp[29:20], 10'h000);
    chk("temp3", temp[39:30], 10'h1FF);
    chk("valid_all", temp_valid, 4'hF);
    repeat (5) tick();

    // Fault on channel 2 after a good read, then recovery.
    sensor_word[2] = 16'h0C80;
    run_round("good2");
    chk("good2_temp", temp[29:20], 10'h064);
    sensor_word[2] = 16'hFFFF;
    run_round("bad2");
    chk("bad2_fault", fault[2], 1);
    chk("bad2_temp_kept", temp[29:20], 10'h064);
    chk("bad2_valid", temp_valid[2], 1);
    sensor_word[2] = 16'h1900;
    run_round("recover2");
    chk("recover2_fault", fault[2], 0);
    chk("recover2_temp", temp[29:20], 10'h0C8);

    // Randomised frames, checked cycle by cycle by the model.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) sensor_word[k] = rand_word();
      repeat ($urandom_range(0, 20)) tick();
      run_round("rand");
    end

    // Auto polling: spacing between successive o_done pulses.
    poll_en = 1'b1;
    wait_done("auto1", PI + RL + 20, w);
    tick();
    wait_done("auto2", PI + RL + 20, w);
    chk("auto_spacing", w + 1, 1561);
    tick();
    repeat (PI + 200) tick();
    poll_en = 1'b0;
    chk("busy_when_poll_dropped", busy, 1);
    wait_done("auto_last", RL + 10, w);
    tick();
    busy_cnt = 0;
    for (int i = 0; i < 2500; i++) begin
      if (busy) busy_cnt++;
      tick();
    end
    chk("no_rounds_after_disable", busy_cnt, 0);

    // Enabling after a long idle starts a round straight away.
    poll_en = 1'b1;
    tick();
    poll_en = 1'b0;
    chk("immediate_poll", busy, 1);
    wait_done("immediate_done", RL + 10, w);
    tick();

    // Reset in the middle of channel 1's shift phase.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (159) tick();
    chk("pre_rst_cs1", cs_n, 4'hD);
    rst = 1'b1;
    #1;
    chk("async_rst_cs_n", cs_n, 4'hF);
    chk("async_rst_sck", sck, 1);
    chk("async_rst_temp", temp, 0);
    chk("async_rst_valid", temp_valid, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    sensor_word[1] = 16'h0C80;
    run_round("after_rst");
    chk("after_rst_temp1", temp[19:10], 10'h064);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
